// File: rtl/multicycle_acc_cpu_if.sv
// Unified instruction/data memory port of the multi-cycle accumulator CPU.
// The core drives the request side; the memory answers with rdata/ready.
interface multicycle_acc_cpu_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multicycle_acc_cpu.sv
// Parametrised multi-cycle accumulator CPU with a single req/ready memory port,
// carry flag, immediate load, conditional branches and a sticky HALT state.
module multicycle_acc_cpu #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_acc_cpu_if.master bus,
    output logic                 halted,
    output logic [ADDR_W-1:0]    pc_dbg,
    output logic [DATA_W-1:0]    acc_dbg,
    output logic                 carry
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_NOT   = 4'h8,
        OP_SHL   = 4'h9,
        OP_SHR   = 4'hA,
        OP_JMP   = 4'hB,
        OP_JZ    = 4'hC,
        OP_JN    = 4'hD,
        OP_LDI   = 4'hE,
        OP_HALT  = 4'hF
    } op_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [DATA_W-1:0] acc, acc_n;
    logic [DATA_W-1:0] ir, ir_n;
    logic              carry_n;

    op_t               op;
    logic [ADDR_W-1:0] arg;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic              unused_ir;

    assign op        = op_t'(ir[DATA_W-1 -: 4]);
    assign arg       = ir[ADDR_W-1:0];
    assign unused_ir = ^ir;

    // Top bit of the extended difference is the unsigned borrow.
    assign sum  = {1'b0, acc} + {1'b0, bus.mem_rdata};
    assign diff = {1'b0, acc} - {1'b0, bus.mem_rdata};

    assign halted  = (state == S_HALT);
    assign pc_dbg  = pc;
    assign acc_dbg = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= ADDR_W'(RESET_PC);
            acc   <= '0;
            ir    <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            acc   <= acc_n;
            ir    <= ir_n;
            carry <= carry_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        acc_n         = acc;
        ir_n          = ir;
        carry_n       = carry;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = acc;

        case (state)
            S_IDLE: state_n = S_FETCH;

            S_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = pc;
                if (bus.mem_ready) begin
                    ir_n    = bus.mem_rdata;
                    pc_n    = pc + 1'b1;
                    state_n = S_DECODE;
                end
            end

            S_DECODE: begin
                state_n = S_FETCH;
                case (op)
                    OP_NOP:  ;
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
                    OP_AND, OP_OR, OP_XOR: state_n = S_MEM;
                    OP_NOT:  acc_n = ~acc;
                    OP_SHL: begin
                        carry_n = acc[DATA_W-1];
                        acc_n   = {acc[DATA_W-2:0], 1'b0};
                    end
                    OP_SHR: begin
                        carry_n = acc[0];
                        acc_n   = {1'b0, acc[DATA_W-1:1]};
                    end
                    OP_JMP:  pc_n = arg;
                    OP_JZ:   if (acc == '0) pc_n = arg;
                    OP_JN:   if (acc[DATA_W-1]) pc_n = arg;
                    OP_LDI:  acc_n = DATA_W'(arg);
                    OP_HALT: state_n = S_HALT;
                    default: ;
                endcase
            end

            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = arg;
                bus.mem_we   = (op == OP_STORE);
                if (bus.mem_ready) begin
                    state_n = S_FETCH;
                    case (op)
                        OP_LOAD: acc_n = bus.mem_rdata;
                        OP_ADD: begin
                            acc_n   = sum[DATA_W-1:0];
                            carry_n = sum[DATA_W];
                        end
                        OP_SUB: begin
                            acc_n   = diff[DATA_W-1:0];
                            carry_n = diff[DATA_W];
                        end
                        OP_AND:  acc_n = acc & bus.mem_rdata;
                        OP_OR:   acc_n = acc | bus.mem_rdata;
                        OP_XOR:  acc_n = acc ^ bus.mem_rdata;
                        default: ;
                    endcase
                end
            end

            S_HALT: ;

            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: doc/multicycle_acc_cpu.md
Name: multicycle_acc_cpu

Overview:
- Parametrised multi-cycle accumulator CPU core. Successor to the single-cycle 16-bit accumulator CPU.
- Has one unified instruction/data memory port with a req/ready handshake, so it tolerates wait-state memories.
- Has a configurable datapath width and address width, a carry flag, immediate load, conditional branches and a sticky HALT state.
- Sits between the system memory wrapper and the debug/LED top level.

Parameters:
- DATA_W, 16: datapath, ACC and instruction width. Must be >= ADDR_W+4.
- ADDR_W, 12: PC and memory address width. Word-addressed.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write, 0 = read. Valid while mem_req.
- mem_addr  out  ADDR_W  transfer address.
- mem_wdata  out  DATA_W  write data (= ACC).
- mem_rdata  in  DATA_W  read data. Valid in the cycle mem_ready=1.
- mem_ready  in  1  transfer completes at the rising edge where mem_req&mem_ready=1.
- halted  out  1  core stopped by HALT.
- pc_dbg  out  ADDR_W  current PC.
- acc_dbg  out  DATA_W  current ACC.
- carry  out  1  carry/borrow/shift-out flag.

Behaviour:
- Instruction format: op = IR[DATA_W-1:DATA_W-4]; arg = IR[ADDR_W-1:0]. Bits in between are ignored.
- Reset, at a clk edge with rst=1:
  - state=IDLE, PC=RESET_PC, ACC=0, IR=0, carry=0, halted=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-transfer abandons the transfer. mem_req is 0 the cycle after the reset edge.
- States: IDLE, FETCH, DECODE, MEM, HALT.
  - IDLE -> FETCH unconditionally on the first edge with rst=0.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On the handshake: IR<=mem_rdata, PC<=PC+1 (wraps mod 2^ADDR_W), then -> DECODE. Otherwise remain in FETCH with outputs stable.
  - DECODE executes non-memory ops and goes -> FETCH:
    - 0 NOP.
    - 8 NOT: ACC=~ACC.
    - 9 SHL: carry=ACC[MSB], ACC<<1.
    - A SHR: carry=ACC[0], ACC>>1 (logical).
    - B JMP: PC=arg.
    - C JZ: PC=arg if ACC==0.
    - D JN: PC=arg if ACC[MSB]=1.
    - E LDI: ACC=zero-extended arg.
    - F HALT: -> HALT.
    - Memory ops 1-7 go -> MEM.
  - MEM: mem_req=1, mem_addr=arg. mem_we=1 only for op 2 (STORE), with mem_wdata=ACC. On the handshake:
    - 1 LOAD: ACC=rdata.
    - 2 STORE: no register change.
    - 3 ADD: {carry,ACC}=ACC+rdata.
    - 4 SUB: ACC=ACC-rdata, carry=borrow (1 when ACC<rdata unsigned).
    - 5 AND, 6 OR, 7 XOR: bitwise with rdata. Carry unchanged.
    - Then -> FETCH.
  - HALT: halted=1, mem_req=0. Remains until rst.
- Outputs mem_req/mem_we/mem_addr/mem_wdata are combinational from the registered state, IR, PC and ACC only. They do not depend on mem_ready.
- Carry changes only on ADD/SUB/SHL/SHR. All other ops leave it unchanged.
- Latency with zero-wait memory (mem_ready tied 1):
  - Non-memory instruction: 2 cycles.
  - Memory instruction: 3 cycles.
  - Each wait cycle adds 1.
- Jump target overrides the PC+1 written during FETCH. JMP to its own address loops forever without fault.
- PC = 2^ADDR_W-1 fetch wraps to 0.
- All arithmetic is modulo 2^DATA_W. The carry is the bit beyond.

Test Plan:
- Reset/start, ready=1, mem[0]=E005 (LDI 5), mem[1]=F000: first mem_req one cycle after rst falls, addr 0. acc_dbg=0x0005 after 2 cycles. halted=1 after cycle 4 and stays; mem_req stays 0.
- Wait states, ready=0 for 3 cycles during FETCH of LDI 7: mem_req/mem_addr held stable. ACC=7 exactly 3 cycles later than the zero-wait case.
- Arithmetic, mem[0x100]=0xFFFF, program LDI 1; ADD 0x100; STORE 0x101: ACC=0x0000, carry=1, write of 0x0000 to 0x101 with mem_we=1 for exactly one handshake. Then SUB 0x100: ACC=0x0001, borrow carry=1.
- Branches, program LDI 0; JZ 0x010; LDI 1: next fetch addr 0x010. With ACC=0x8000, JN taken; with ACC=0x7FFF, JN not taken (PC+1).
- Reset mid-MEM: assert rst while mem_req=1, mem_we=1, ready=0 → after the edge mem_req=0, PC=RESET_PC, ACC=0, carry=0. No write completes.
- Parametrisation with DATA_W=24, ADDR_W=16: PC wrap from 0xFFFF to 0x0000. SHL of 0x800000 gives ACC=0, carry=1.
